// File: rtl/freq_meter_gen.sv
// Gated frequency meter: counts rising edges of clk_test over GATE_CYCLES clocks and
// presents the result on the seven-segment data bus, in Hz or in kHz with a decimal point.
module freq_meter_gen #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int HZ_LIMIT    = 1_000_000,
    parameter int KDIV        = 1000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        clk_test,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        seg_en,
    output logic        sign,
    output logic        meas_done
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int HW = $clog2(HZ_LIMIT + 1);
    localparam int SW = (KDIV > 1) ? $clog2(KDIV) : 1;

    localparam logic [GW-1:0] GATE_LAST_VAL = GW'(GATE_CYCLES - 1);
    localparam logic [HW-1:0] HZ_MAX        = HW'(HZ_LIMIT);
    localparam logic [SW-1:0] SUB_LAST      = SW'(KDIV - 1);
    localparam logic [19:0]   DISP_MAX      = 20'd999_999;
    localparam logic [5:0]    KHZ_POINT     = 6'b001000;

    logic [2:0]    sync_reg;
    logic          rise;
    logic          gate_last;

    logic [GW-1:0] gate_cnt_reg;
    logic [HW-1:0] cnt_hz_reg;
    logic [SW-1:0] sub_cnt_reg;
    logic [19:0]   cnt_khz_reg;

    logic [HW-1:0] hz_next;
    logic [SW-1:0] sub_next;
    logic [19:0]   khz_next;
    logic          sub_wrap;
    logic [31:0]   hz_wide;
    logic          hz_in_range;

    logic [19:0]   data_reg;
    logic [5:0]    point_reg;
    logic          seg_en_reg;
    logic          meas_done_reg;

    // sync_reg[0..1] resynchronise the async input; sync_reg[2] is the edge-detect delay
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], clk_test};
        end
    end

    assign rise      = sync_reg[1] & ~sync_reg[2];
    assign gate_last = (gate_cnt_reg == GATE_LAST_VAL);

    // Counter values including this cycle's rise; on gate_last these are the window results
    always_comb begin
        hz_next = cnt_hz_reg;
        if (rise && (cnt_hz_reg != HZ_MAX)) begin
            hz_next = cnt_hz_reg + 1'b1;
        end

        sub_wrap = rise && (sub_cnt_reg == SUB_LAST);
        sub_next = sub_cnt_reg;
        if (rise) begin
            sub_next = sub_wrap ? '0 : sub_cnt_reg + 1'b1;
        end

        khz_next = cnt_khz_reg;
        if (sub_wrap && (cnt_khz_reg != DISP_MAX)) begin
            khz_next = cnt_khz_reg + 1'b1;
        end
    end

    assign hz_wide     = 32'(hz_next);
    assign hz_in_range = (hz_wide < 32'(HZ_LIMIT)) && (hz_wide <= 32'd999_999);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gate_cnt_reg <= '0;
            cnt_hz_reg   <= '0;
            sub_cnt_reg  <= '0;
            cnt_khz_reg  <= '0;
        end else if (gate_last) begin
            gate_cnt_reg <= '0;
            cnt_hz_reg   <= '0;
            sub_cnt_reg  <= '0;
            cnt_khz_reg  <= '0;
        end else begin
            gate_cnt_reg <= gate_cnt_reg + 1'b1;
            cnt_hz_reg   <= hz_next;
            sub_cnt_reg  <= sub_next;
            cnt_khz_reg  <= khz_next;
        end
    end

    // Display registers only change at a window end and otherwise hold the last result
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            data_reg      <= '0;
            point_reg     <= '0;
            seg_en_reg    <= 1'b0;
            meas_done_reg <= 1'b0;
        end else begin
            meas_done_reg <= gate_last;
            if (gate_last) begin
                seg_en_reg <= 1'b1;
                if (hz_in_range) begin
                    data_reg  <= hz_wide[19:0];
                    point_reg <= '0;
                end else begin
                    data_reg  <= khz_next;
                    point_reg <= KHZ_POINT;
                end
            end
        end
    end

    assign data      = data_reg;
    assign point     = point_reg;
    assign seg_en    = seg_en_reg;
    assign sign      = 1'b0;
    assign meas_done = meas_done_reg;

endmodule

// File: tb/tb_freq_meter_gen.sv
// Bench for freq_meter_gen: per-window edge-count model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_freq_meter_gen;
    localparam int GATE = 1000;
    localparam int HZL  = 100;
    localparam int KD   = 10;

    logic        sys_clk  = 1'b0;
    logic        sys_rst  = 1'b1;
    logic        clk_test = 1'b0;
    logic [19:0] data;
    logic [5:0]  point;
    logic        seg_en;
    logic        sign;
    logic        meas_done;

    int checks = 0;
    int errors = 0;

    freq_meter_gen #(
        .GATE_CYCLES(GATE),
        .HZ_LIMIT   (HZL),
        .KDIV       (KD)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .clk_test (clk_test),
        .data     (data),
        .point    (point),
        .seg_en   (seg_en),
        .sign     (sign),
        .meas_done(meas_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Test-signal generator: square wave of gen_period cycles (low half first), or a
    // static manual_level when gen_period is 0. Bumping gen_epoch restarts the phase.
    int   gen_period   = 0;
    int   gen_epoch    = 0;
    logic manual_level = 1'b0;

    initial begin : gen
        int phase;
        int seen;
        phase = 0;
        seen  = 0;
        forever begin
            @(negedge sys_clk);
            #1;
            if (gen_epoch != seen) begin
                seen  = gen_epoch;
                phase = 0;
            end
            if (gen_period > 0) begin
                clk_test = (phase >= gen_period / 2);
                phase    = (phase + 1) % gen_period;
            end else begin
                clk_test = manual_level;
            end
        end
    end

    // Model: cycle c = c-th cycle after the last reset clock. samp[c] is clk_test as seen
    // at the clock that starts cycle c (forced 0 for c<=0). A rise lands in cycle c when
    // samp[c-2]=0 and samp[c-1]=1. Rises are totalled per window of GATE cycles and the
    // total is shown from the first cycle of the following window.
    bit   m_valid = 0;
    int   m_cyc;
    int   m_cnt;
    bit   samp[int];
    logic [31:0] e_data;
    logic [31:0] e_point;
    logic        e_seg;
    logic        e_done;

    initial begin : model
        bit prev1, prev2;
        forever begin
            @(posedge sys_clk);
            if (sys_rst) begin
                m_valid = 1;
                m_cyc   = 0;
                m_cnt   = 0;
                samp.delete();
                e_data  = 0;
                e_point = 0;
                e_seg   = 0;
                e_done  = 0;
            end else if (m_valid) begin
                prev1 = (m_cyc >= 1) ? samp[m_cyc - 1] : 1'b0;
                prev2 = (m_cyc >= 2) ? samp[m_cyc - 2] : 1'b0;
                if (prev1 && !prev2) m_cnt++;
                e_done = 0;
                if (m_cyc % GATE == GATE - 1) begin
                    e_done = 1;
                    e_seg  = 1;
                    if (m_cnt < HZL && m_cnt <= 999_999) begin
                        e_data  = m_cnt;
                        e_point = 0;
                    end else begin
                        e_data  = (m_cnt / KD > 999_999) ? 999_999 : m_cnt / KD;
                        e_point = 8;
                    end
                    m_cnt = 0;
                end
                if (m_cyc >= 2) samp.delete(m_cyc - 2);
                samp[m_cyc + 1] = clk_test;
                m_cyc++;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge sys_clk);
            if (m_valid) begin
                chk("data",      data,      e_data);
                chk("point",     point,     e_point);
                chk("seg_en",    seg_en,    e_seg);
                chk("sign",      sign,      0);
                chk("meas_done", meas_done, e_done);
            end
        end
    end

    // Returns the number of negedges until meas_done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!meas_done && n < GATE + 100);
        if (!meas_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no meas_done within %0d cycles, expected one", n);
        end else begin
            $display("window: data=%0d point=%b seg_en=%b after %0d cycles", data, point, seg_en, n);
        end
    endtask

    initial begin : main
        int n;

        // Reset held 5 cycles with the input already toggling
        sys_rst    = 1'b1;
        gen_period = 20;
        gen_epoch++;
        repeat (5) @(negedge sys_clk);
        chk("rst_data",   data,      0);
        chk("rst_seg_en", seg_en,    0);
        chk("rst_done",   meas_done, 0);
        sys_rst = 1'b0;

        // Hz range, period 20
        wait_done(n);
        chk("first_done_latency", n, 1000);
        chk("hz_first_49_or_50", (data == 49 || data == 50), 1);
        chk("hz_point", point, 0);
        chk("hz_seg_en", seg_en, 1);
        wait_done(n);
        chk("hz_period", n, 1000);
        chk("hz_steady", data, 50);

        // kHz range, period 4 -> 250 edges
        gen_period = 4;
        gen_epoch++;
        wait_done(n);
        wait_done(n);
        chk("khz_data", data, 25);
        chk("khz_point", point, 8);

        // Boundary: exactly HZ_LIMIT edges selects kHz
        gen_period = 10;
        gen_epoch++;
        wait_done(n);
        wait_done(n);
        chk("limit_data", data, 10);
        chk("limit_point", point, 8);

        // Stopped input
        gen_period   = 0;
        manual_level = 1'b0;
        wait_done(n);
        wait_done(n);
        chk("stop_period", n, 1000);
        chk("stop_data", data, 0);
        chk("stop_point", point, 0);
        chk("stop_seg_en", seg_en, 1);

        // Single rise landing on gate_last (input rises 2 cycles before it)
        repeat (997) @(negedge sys_clk);
        manual_level = 1'b1;
        wait_done(n);
        chk("edge_last_latency", n, 3);
        chk("edge_last_data", data, 1);
        wait_done(n);
        chk("edge_next_data", data, 0);
        manual_level = 1'b0;

        // Reset mid-window at gate_cnt = 500
        gen_period = 20;
        gen_epoch++;
        wait_done(n);
        wait_done(n);
        chk("pre_rst_data", data, 50);
        repeat (500) @(negedge sys_clk);
        sys_rst = 1'b1;
        gen_epoch++;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("midrst_data", data, 0);
        chk("midrst_seg_en", seg_en, 0);
        chk("midrst_point", point, 0);
        wait_done(n);
        chk("midrst_latency", n, 1000);
        chk("midrst_full_count", (data == 49 || data == 50), 1);
        chk("midrst_seg_en_after", seg_en, 1);

        repeat (5) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
